// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
// Buffer depth, default word width and pointer helper.
package fifo_rd_stream_pkg;

  localparam int DATASIZE_DFLT = 8;
  localparam int BUF_DEPTH     = 3;

  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Three-entry circular buffer: push at tail, pop at head,
// synchronous clear, occupancy and head word out.
module rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW = DATASIZE_DFLT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_occ
);

  logic [DW-1:0] r_mem [BUF_DEPTH];
  logic [1:0]    r_head;
  logic [1:0]    r_tail;
  logic [1:0]    r_occ;

  // Storage, pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (i_clr) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_wdata;
        r_tail        <= ptr_inc(r_tail);
      end
      if (i_pop) begin
        r_head <= ptr_inc(r_head);
      end
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head = r_mem[r_head];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter (read domain).
// Requests are issued from registered state only, never m_ready.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DFLT,
  parameter int CNTSIZE  = 16
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                empty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic                m_valid,
  output logic [DATASIZE-1:0] m_data,
  input  logic                m_ready,
  input  logic                flush,
  output logic [CNTSIZE-1:0]  xfer_cnt,
  output logic                busy
);

  logic               r_pend;
  logic [CNTSIZE-1:0] r_cnt;
  logic [1:0]         w_occ;
  logic [2:0]         w_fill;
  logic               w_hs;
  logic               w_push;
  logic               w_pop;

  // Pop request: room for one more counting the word in flight.
  // Gated by rst_n so the FIFO is never popped while held in reset.
  always_comb begin
    w_fill = {1'b0, w_occ} + {2'b00, r_pend};
    rinc   = rst_n && !empty && !flush
             && (w_fill < 3'(BUF_DEPTH));
  end

  assign m_valid = (w_occ != 2'd0);
  assign w_hs    = m_valid && m_ready;
  assign w_push  = r_pend && !flush;
  assign w_pop   = w_hs && !flush;

  rd_skid_buf #(
    .DW(DATASIZE)
  ) u_buf (
    .i_clk  (rclk),
    .i_rst_n(rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clr  (flush),
    .i_wdata(rdata),
    .o_head (m_data),
    .o_occ  (w_occ)
  );

  // In-flight tracker: RAM returns data one cycle after rinc.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= rinc;
    end
  end

  // Completed handshakes; a flush-cycle handshake is discarded.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign xfer_cnt = r_cnt;
  assign busy     = m_valid || r_pend;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural FIFO
// read port (one-cycle read latency) and CNTSIZE = 4.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rst_n;
  logic          empty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          flush;
  logic [CW-1:0] xfer_cnt;
  logic          busy;

  int n_cmp    = 0;
  int n_err    = 0;
  int rinc_cnt = 0;
  int outst    = 0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(
    .DATASIZE(DW),
    .CNTSIZE (CW)
  ) dut (
    .rclk    (rclk),
    .rst_n   (rst_n),
    .empty   (empty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .flush   (flush),
    .xfer_cnt(xfer_cnt),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One clock: sample the pop request, then model the RAM read.
  task automatic tick();
    logic r;
    @(negedge rclk);
    r = rinc;
    if (r) rinc_cnt++;
    @(posedge rclk);
    #1;
    if (r && src.size() != 0) rdata = src.pop_front();
    empty = (src.size() == 0);
  endtask

  task automatic load(input logic [7:0] first, input int n,
                      input bit to_exp);
    for (int i = 0; i < n; i++) begin
      src.push_back(first + 8'(i));
      if (to_exp) exp_q.push_back(first + 8'(i));
    end
    empty = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Monitor: ordering, stall stability and request-limit checks.
  always @(negedge rclk) begin
    if (!rst_n) begin
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (outst >= 3) chk("rinc_full", rinc, 0);
      if (m_valid && m_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h want none", m_data);
        end else begin
          chk("data", m_data, exp_q.pop_front());
        end
      end
      if (flush) outst = 0;
      else outst = outst + int'(rinc) - int'(m_valid && m_ready);
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    empty   = 1'b0;
    rdata   = '0;
    m_ready = 1'b0;
    flush   = 1'b0;
    #2;
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst_busy", busy, 0);
    empty = 1'b1;
    @(posedge rclk);
    #1;
    rst_n = 1'b1;
    tick();

    // stream of 8 words, m_ready high
    m_ready = 1'b1;
    load(8'h01, 8, 1'b1);
    n = 0;
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    chk("latency", n, 2);
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", m_valid, 1);
      tick();
    end
    chk("stream_cnt", xfer_cnt, 8);
    chk("stream_busy", busy, 0);
    chk("stream_left", exp_q.size(), 0);

    // backpressure with 10 words
    m_ready  = 1'b0;
    rinc_cnt = 0;
    load(8'h10, 10, 1'b1);
    repeat (8) tick();
    chk("bp_pulses", rinc_cnt, 3);
    chk("bp_rinc", rinc, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, 8'h10);
    m_ready = 1'b1;
    drain(40);
    repeat (2) tick();
    chk("bp_cnt", xfer_cnt, 2);
    chk("bp_busy", busy, 0);

    // random backpressure over 256 words
    load(8'h00, 256, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("rand_done", exp_q.size(), 0);
    m_ready = 1'b1;
    repeat (2) tick();
    chk("rand_cnt", xfer_cnt, 2);
    chk("rand_busy", busy, 0);

    // flush with two buffered and one in flight
    m_ready = 1'b0;
    load(8'h40, 6, 1'b0);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h45);
    repeat (3) tick();
    chk("pre_flush_rinc", rinc, 0);
    chk("pre_flush_busy", busy, 1);
    flush   = 1'b1;
    m_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", m_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_cnt", xfer_cnt, 2);
    drain(40);
    repeat (2) tick();
    chk("post_flush_cnt", xfer_cnt, 5);

    // asynchronous reset mid-stream
    load(8'h60, 20, 1'b1);
    repeat (4) tick();
    chk("mid_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rinc", rinc, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_cnt", xfer_cnt, 0);
    chk("arst_busy", busy, 0);
    src.delete();
    exp_q.delete();
    empty = 1'b1;
    rdata = '0;
    @(posedge rclk);
    #1;
    rst_n = 1'b1;
    tick();

    // counter wrap: 17 handshakes on a 4-bit counter
    load(8'h80, 17, 1'b1);
    drain(60);
    repeat (2) tick();
    chk("wrap_cnt", xfer_cnt, 1);
    chk("wrap_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
